sdram_config_poller: RTL and testbench

SDRAM_CONFIG_POLLER -- requirements
Module: sdram_config_poller

---
 rtl/sdram_pkg.sv | 27 ++
 rtl/sdram_config_poller_if.sv | 39 +++
 rtl/down_counter.sv | 41 ++++
 rtl/sdram_config_poller.sv | 150 +++++++++++++++
 tb/tb_sdram_config_poller.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  sdram_pkg
//  Shared types for the SDRAM configuration status poller.
//  Revision: 1.0
// ============================================================================
package sdram_pkg;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_INTERVAL = 3'd2,
      ST_DONE     = 3'd3,
      ST_FAIL     = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      FAIL_NONE        = 2'b00,
      FAIL_POLL_LIMIT  = 2'b01,
      FAIL_ACK_TIMEOUT = 2'b10
   } fail_code_t;

endpackage
`default_nettype wire

// File: rtl/sdram_config_poller_if.sv
`default_nettype none
// ============================================================================
//  sdram_config_poller_if
//  Word-access initiator bus between the poller and the SDRAM controller.
//  Revision: 1.0
// ============================================================================
interface sdram_config_poller_if;
   import sdram_pkg::*;

   logic [ADDR_W-1:0] data_m_addr;
   logic [DATA_W-1:0] data_m_data_in;
   logic [DATA_W-1:0] data_m_data_out;
   logic              data_m_access;
   logic              data_m_wr_en;
   logic [1:0]        data_m_bytesel;
   logic              data_m_ack;

   modport master (
      output data_m_addr,
      output data_m_data_out,
      output data_m_access,
      output data_m_wr_en,
      output data_m_bytesel,
      input  data_m_data_in,
      input  data_m_ack
   );

   modport slave (
      input  data_m_addr,
      input  data_m_data_out,
      input  data_m_access,
      input  data_m_wr_en,
      input  data_m_bytesel,
      output data_m_data_in,
      output data_m_ack
   );

endinterface
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
//  down_counter
//  Loadable down-counter that stops at zero and flags it.
//  Revision: 1.0
// ============================================================================
module down_counter #(
   parameter int WIDTH = 8
) (
   input  wire              clk,
   input  wire              rst_n,
   input  wire              load_i,
   input  wire [WIDTH-1:0]  load_val_i,
   input  wire              dec_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/sdram_config_poller.sv
`default_nettype none
// ============================================================================
//  sdram_config_poller
//  Polls the SDRAM config status word until bit 0 is set, with retry limit
//  and per-access acknowledge timeout.
//  Revision: 1.0
// ============================================================================
module sdram_config_poller
   import sdram_pkg::*;
#(
   parameter logic [18:0] STATUS_ADDR   = 19'h7fff0,
   parameter int unsigned POLL_INTERVAL = 16,
   parameter int unsigned MAX_POLLS     = 1024,
   parameter int unsigned ACK_TIMEOUT   = 255
) (
   input  wire                    clk,
   input  wire                    reset_n,
   input  wire                    start,
   sdram_config_poller_if.master  data_m,
   output logic                   busy,
   output logic                   done,
   output logic                   fail,
   output logic [1:0]             fail_code
);

   // Counters stop at zero, so a load of N-1 yields a phase of exactly N cycles.
   localparam logic [15:0] C_INTERVAL_LOAD = 16'(POLL_INTERVAL - 1);
   localparam logic [7:0]  C_ACK_LOAD      = 8'(ACK_TIMEOUT - 1);
   localparam logic [16:0] C_MAX_POLLS     = 17'(MAX_POLLS);

   state_t     state_q, state_d;
   logic [15:0] poll_count_q, poll_count_d;
   logic       done_q, done_d;
   logic       fail_q, fail_d;
   fail_code_t fail_code_q, fail_code_d;

   logic        ack_load, ack_dec, ack_zero;
   logic        int_load, int_dec, int_zero;
   logic [16:0] polls_next;
   logic        unused_status_bits;

   assign polls_next         = {1'b0, poll_count_q} + 17'd1;
   assign unused_status_bits = ^data_m.data_m_data_in[15:1];

   always_comb begin
      state_d      = state_q;
      poll_count_d = poll_count_q;
      done_d       = done_q;
      fail_d       = fail_q;
      fail_code_d  = fail_code_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_READ;
               poll_count_d = '0;
            end
         end
         ST_READ: begin
            // An ack on the final wait cycle wins over the timeout.
            if (data_m.data_m_ack) begin
               if (poll_count_q != 16'hffff) begin
                  poll_count_d = poll_count_q + 16'd1;
               end
               if (data_m.data_m_data_in[0]) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (polls_next == C_MAX_POLLS) begin
                  state_d     = ST_FAIL;
                  fail_d      = 1'b1;
                  fail_code_d = FAIL_POLL_LIMIT;
               end else begin
                  state_d = ST_INTERVAL;
               end
            end else if (ack_zero) begin
               state_d     = ST_FAIL;
               fail_d      = 1'b1;
               fail_code_d = FAIL_ACK_TIMEOUT;
            end
         end
         ST_INTERVAL: begin
            if (int_zero) begin
               state_d = ST_READ;
            end
         end
         ST_DONE, ST_FAIL: begin
            if (start) begin
               state_d      = ST_READ;
               poll_count_d = '0;
               done_d       = 1'b0;
               fail_d       = 1'b0;
               fail_code_d  = FAIL_NONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         poll_count_q <= '0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
         fail_code_q  <= FAIL_NONE;
      end else begin
         state_q      <= state_d;
         poll_count_q <= poll_count_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
         fail_code_q  <= fail_code_d;
      end
   end

   assign ack_load = (state_d == ST_READ) && (state_q != ST_READ);
   assign ack_dec  = (state_q == ST_READ);
   assign int_load = (state_d == ST_INTERVAL) && (state_q != ST_INTERVAL);
   assign int_dec  = (state_q == ST_INTERVAL);

   down_counter #(.WIDTH(8)) u_ack_wait (
      .clk        (clk),
      .rst_n      (reset_n),
      .load_i     (ack_load),
      .load_val_i (C_ACK_LOAD),
      .dec_i      (ack_dec),
      .zero_o     (ack_zero)
   );

   down_counter #(.WIDTH(16)) u_interval (
      .clk        (clk),
      .rst_n      (reset_n),
      .load_i     (int_load),
      .load_val_i (C_INTERVAL_LOAD),
      .dec_i      (int_dec),
      .zero_o     (int_zero)
   );

   // Bus outputs decode straight from the state so reset drops them at once.
   assign data_m.data_m_access   = (state_q == ST_READ);
   assign data_m.data_m_addr     = (state_q == ST_READ) ? STATUS_ADDR : '0;
   assign data_m.data_m_data_out = '0;
   assign data_m.data_m_wr_en    = 1'b0;
   assign data_m.data_m_bytesel  = (state_q == ST_READ) ? 2'b11 : 2'b00;

   assign busy      = (state_q == ST_READ) || (state_q == ST_INTERVAL);
   assign done      = done_q;
   assign fail      = fail_q;
   assign fail_code = fail_code_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_config_poller.sv
`default_nettype none
// ============================================================================
//  tb_sdram_config_poller
//  Scoreboard bench: expected accesses queued by stimulus, checked by monitor.
//  Revision: 1.0
// ============================================================================
module tb_sdram_config_poller;
   import sdram_pkg::*;

   localparam logic [18:0] C_ADDR = 19'h7fff0;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       busy, done, fail;
   logic [1:0] fail_code;

   int checks = 0;
   int errors = 0;

   sdram_config_poller_if bus ();

   sdram_config_poller #(
      .POLL_INTERVAL (16),
      .MAX_POLLS     (4),
      .ACK_TIMEOUT   (255)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .data_m    (bus.master),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .fail_code (fail_code)
   );

   initial forever #5 clk = ~clk;

   typedef struct { int delay; logic [15:0] data; } rsp_t;
   typedef struct { logic [18:0] addr; int len; int gap; } acc_t;
   rsp_t rsp_q[$];
   acc_t exp_q[$];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic push_rsp(input int delay, input logic [15:0] data);
      rsp_t r;
      r.delay = delay;
      r.data  = data;
      rsp_q.push_back(r);
   endtask

   task automatic push_exp(input int len, input int gap);
      acc_t e;
      e.addr = C_ADDR;
      e.len  = len;
      e.gap  = gap;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_end(input int max_cycles);
      int n = 0;
      while (!(done || fail) && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!(done || fail)) begin
         errors++;
         $display("FAIL wait_end timeout actual=busy required=done_or_fail at %0t", $time);
      end
      @(negedge clk);
   endtask

   // Responder: acks the access when it has been high for delay+1 cycles.
   initial begin
      int  cnt = 0;
      bit  acked = 1'b0;
      bus.data_m_ack     = 1'b0;
      bus.data_m_data_in = 16'h0;
      forever begin
         @(negedge clk);
         if (bus.data_m_access) begin
            cnt++;
            if (rsp_q.size() > 0 && cnt == rsp_q[0].delay + 1) begin
               bus.data_m_ack     = 1'b1;
               bus.data_m_data_in = rsp_q[0].data;
               acked = 1'b1;
            end else begin
               bus.data_m_ack     = 1'b0;
               bus.data_m_data_in = 16'h0;
            end
         end else begin
            if (acked) rsp_q.delete(0);
            acked = 1'b0;
            cnt   = 0;
            bus.data_m_ack     = 1'b0;
            bus.data_m_data_in = 16'h0;
         end
      end
   end

   // Monitor: measures each access burst and compares against the scoreboard.
   initial begin
      logic        prev = 1'b0;
      logic [18:0] a = '0;
      int          len = 0;
      int          low = 0;
      int          gap = 0;
      bit          side_bad = 1'b0;
      acc_t        e;
      forever begin
         @(negedge clk);
         if (bus.data_m_access) begin
            if (!prev) begin
               gap = low;
               low = 0;
               len = 0;
               a   = bus.data_m_addr;
            end
            len++;
            if (bus.data_m_addr != C_ADDR || bus.data_m_bytesel != 2'b11 ||
                bus.data_m_wr_en || bus.data_m_data_out != 16'h0)
               side_bad = 1'b1;
         end else begin
            if (bus.data_m_bytesel != 2'b00 || bus.data_m_wr_en) side_bad = 1'b1;
            if (prev) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_access actual=len%0d required=none at %0t", len, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("acc_addr", int'(a), int'(e.addr));
                  if (e.len >= 0) check("acc_len", len, e.len);
                  if (e.gap >= 0) check("acc_gap", gap, e.gap);
                  check("acc_sideband", int'(side_bad), 0);
               end
               side_bad = 1'b0;
            end
            low++;
         end
         prev = bus.data_m_access;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_access", int'(bus.data_m_access), 0);
      check("rst_addr", int'(bus.data_m_addr), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_fail", int'(fail), 0);
      check("rst_code", int'(fail_code), 0);

      // Poll not-ready, 0xfffe (bit0 clear), then ready; start on first edge out of reset
      push_rsp(1, 16'h0000); push_rsp(1, 16'hfffe); push_rsp(1, 16'h0001);
      push_exp(2, -1); push_exp(2, 16); push_exp(2, 16);
      reset_n = 1'b1;
      start   = 1'b1;
      @(negedge clk) start = 1'b0;
      check("first_start_busy", int'(busy), 1);
      check("first_start_access", int'(bus.data_m_access), 1);
      wait_end(200);
      check("t1_done", int'(done), 1);
      check("t1_busy", int'(busy), 0);
      check("t1_fail", int'(fail), 0);
      check("t1_code", int'(fail_code), 0);
      check("t1_pending", exp_q.size(), 0);

      // Restart from DONE; start inside INTERVAL must be ignored; count restarts at 0
      push_rsp(1, 16'h0000); push_rsp(1, 16'h0000); push_rsp(1, 16'h0000); push_rsp(1, 16'h8001);
      push_exp(2, -1); push_exp(2, 16); push_exp(2, 16); push_exp(2, 16);
      pulse_start();
      check("t2_done_cleared", int'(done), 0);
      check("t2_busy", int'(busy), 1);
      repeat (5) @(negedge clk);
      pulse_start();
      check("t2_ignored_access", int'(bus.data_m_access), 0);
      check("t2_ignored_busy", int'(busy), 1);
      wait_end(300);
      check("t2_done", int'(done), 1);
      check("t2_code", int'(fail_code), 0);
      check("t2_pending", exp_q.size(), 0);

      // Poll limit
      repeat (4) push_rsp(1, 16'h0000);
      push_exp(2, -1); push_exp(2, 16); push_exp(2, 16); push_exp(2, 16);
      pulse_start();
      wait_end(300);
      check("t3_fail", int'(fail), 1);
      check("t3_code", int'(fail_code), int'(FAIL_POLL_LIMIT));
      check("t3_done", int'(done), 0);
      check("t3_busy", int'(busy), 0);
      repeat (40) @(negedge clk);
      check("t3_no_fifth", int'(bus.data_m_access), 0);
      check("t3_pending", exp_q.size(), 0);

      // Ack timeout
      push_exp(255, -1);
      pulse_start();
      wait_end(400);
      check("t4_fail", int'(fail), 1);
      check("t4_code", int'(fail_code), int'(FAIL_ACK_TIMEOUT));
      check("t4_access", int'(bus.data_m_access), 0);
      check("t4_pending", exp_q.size(), 0);

      // Ack on the last permitted wait cycle counts as an ack
      push_rsp(254, 16'h0003);
      push_exp(255, -1);
      pulse_start();
      wait_end(400);
      check("t5_done", int'(done), 1);
      check("t5_fail", int'(fail), 0);
      check("t5_code", int'(fail_code), 0);
      check("t5_pending", exp_q.size(), 0);

      // Reset in the middle of an outstanding access
      push_exp(-1, -1);
      pulse_start();
      repeat (4) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("t6_access", int'(bus.data_m_access), 0);
      check("t6_addr", int'(bus.data_m_addr), 0);
      check("t6_bytesel", int'(bus.data_m_bytesel), 0);
      check("t6_busy", int'(busy), 0);
      check("t6_done", int'(done), 0);
      check("t6_fail", int'(fail), 0);
      check("t6_code", int'(fail_code), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      push_rsp(1, 16'h0001);
      push_exp(2, -1);
      pulse_start();
      wait_end(100);
      check("t6_restart_done", int'(done), 1);
      check("t6_restart_fail", int'(fail), 0);
      check("t6_pending", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
